// File: rtl/ram_sp_ctrl_if.sv
// Request/response channel bundle between a client and ram_sp_ctrl.
// The client side uses the master modport, the controller the slave modport.
interface ram_sp_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/ram_sp_ctrl.sv
// Front-end controller for the single-port synchronous RAM (shared tristate
// data bus, cs/we/oe). Accepts one word request at a time, sequences the RAM
// pins, and returns read data on a backpressured response channel. The RSP
// state doubles as the read-to-write bus turnaround cycle.
module ram_sp_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   ram_sp_ctrl_if.slave          bus,
   output logic [ADDR_WIDTH-1:0] ram_address,
   inout  wire  [DATA_WIDTH-1:0] ram_data,
   output logic                  ram_cs,
   output logic                  ram_we,
   output logic                  ram_oe
);

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD_ADDR,
      RD_DATA,
      RSP
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic                  ready_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  bus_drive;
   logic                  accept;

   // ready_q is only ever set while heading into IDLE, so it alone qualifies acceptance
   assign accept = ready_q & bus.req_valid;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and RAM pin decode; pins depend on state only
   always_comb begin
      state_d   = state_q;
      ram_cs    = 1'b0;
      ram_we    = 1'b0;
      ram_oe    = 1'b0;
      bus_drive = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = bus.req_we ? WR : RD_ADDR;
            end
         end
         WR: begin
            ram_cs    = 1'b1;
            ram_we    = 1'b1;
            bus_drive = 1'b1;
            state_d   = IDLE;
         end
         RD_ADDR: begin
            ram_cs  = 1'b1;
            ram_oe  = 1'b1;
            state_d = RD_DATA;
         end
         RD_DATA: begin
            ram_cs  = 1'b1;
            ram_oe  = 1'b1;
            state_d = RSP;
         end
         RSP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request capture, registered ready and read-data sampling
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         // Registered from the next state so ready stays low for the cycle after reset
         ready_q <= (state_d == IDLE);
         if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         if (state_q == RD_DATA) begin
            rdata_q <= ram_data;
         end
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = (state_q == RSP);
   assign bus.rsp_rdata = rdata_q;
   assign ram_address   = addr_q;
   assign ram_data      = bus_drive ? wdata_q : 'z;

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// Bench for ram_sp_ctrl: a behavioural RAM on the shared bus, a transaction
// level model of the expected pin/channel behaviour checked every cycle, and
// directed scenarios with literal expectations.
module tb_ram_sp_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   wire  [7:0] ram_data;
   logic [7:0] ram_address;
   logic       ram_cs;
   logic       ram_we;
   logic       ram_oe;

   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned cyc   = 0;

   always #5 clk = ~clk;

   ram_sp_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

   ram_sp_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_cs      (ram_cs),
      .ram_we      (ram_we),
      .ram_oe      (ram_oe)
   );

   // ---------------- behavioural single-port RAM ----------------
   logic [7:0] ram_mem [256];
   logic [7:0] ram_q;

   initial begin
      for (int i = 0; i < 256; i++) ram_mem[i] = 8'h00;
      ram_q = 8'h00;
   end

   always @(posedge clk) begin
      if (ram_cs && ram_we) ram_mem[ram_address] <= ram_data;
      else if (ram_cs && ram_oe) ram_q <= ram_mem[ram_address];
   end

   assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : 8'bz;

   // ---------------- checking helper ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   initial forever @(posedge clk) cyc++;

   // ---------------- transaction-level model ----------------
   // Busy cycles still owed by the controller: a write owes one bus cycle,
   // a read owes two bus cycles followed by an open-ended response phase.
   typedef struct {
      bit         is_wr;
      logic [7:0] addr;
      logic [7:0] data;
   } busy_t;

   busy_t      m_q[$];
   logic [7:0] m_mem [256];
   bit         m_live = 1'b0;
   bit         m_ready = 1'b0;
   bit         m_rsp = 1'b0;
   logic [7:0] m_rsp_data;
   logic [7:0] m_addr;
   logic [7:0] m_rdata;

   initial begin
      bit accept;
      bit rsp_done;
      bit last_rd;
      for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
      forever begin
         @(posedge clk);
         // the RAM commits a write in flight even if reset arrives at the same edge
         if (m_q.size() > 0 && m_q[0].is_wr) m_mem[m_q[0].addr] = m_q[0].data;
         if (rst) begin
            m_q.delete();
            m_rsp   = 1'b0;
            m_rdata = 8'h00;
            m_addr  = 8'h00;
            m_ready = 1'b0;
            m_live  = 1'b1;
         end else begin
            accept   = m_ready && bus.req_valid;
            rsp_done = (m_q.size() == 0) && m_rsp && bus.rsp_ready;
            if (m_q.size() > 0) begin
               last_rd = !m_q[0].is_wr && (m_q.size() == 1);
               void'(m_q.pop_front());
               if (last_rd) m_rdata = m_rsp_data;
            end
            if (rsp_done) m_rsp = 1'b0;
            if (accept) begin
               m_addr = bus.req_addr;
               if (bus.req_we) begin
                  m_q.push_back('{is_wr: 1'b1, addr: bus.req_addr, data: bus.req_wdata});
               end else begin
                  m_q.push_back('{is_wr: 1'b0, addr: bus.req_addr, data: 8'h00});
                  m_q.push_back('{is_wr: 1'b0, addr: bus.req_addr, data: 8'h00});
                  m_rsp      = 1'b1;
                  m_rsp_data = m_mem[bus.req_addr];
               end
            end
            m_ready = (m_q.size() == 0) && !m_rsp;
         end
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   initial forever begin
      logic [4:0] exp_pins;
      @(negedge clk);
      if (m_live) begin
         if (m_q.size() > 0) exp_pins = {1'b1, m_q[0].is_wr, !m_q[0].is_wr, 1'b0, 1'b0};
         else                exp_pins = {3'b000, m_rsp, m_ready};
         chk("pins{cs,we,oe,rsp_valid,req_ready}",
             {27'd0, ram_cs, ram_we, ram_oe, bus.rsp_valid, bus.req_ready}, {27'd0, exp_pins});
         chk("ram_address", {24'd0, ram_address}, {24'd0, m_addr});
         chk("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, m_rdata});
         chk("we_and_oe", {31'd0, ram_we & ram_oe}, 32'd0);
         if (m_q.size() > 0 && m_q[0].is_wr)
            chk("wr_bus_data", {24'd0, ram_data}, {24'd0, m_q[0].data});
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d,
                        output int unsigned acc);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.req_ready === 1'b1) begin
            @(posedge clk);
            #1;
            acc = cyc;
            bus.req_valid = 1'b0;
            bus.req_we    = ~we;
            bus.req_addr  = ~a;
            bus.req_wdata = ~d;
            return;
         end
      end
      tests++;
      fails++;
      $display("FAIL accept_timeout: got no acceptance, expected acceptance within 40 cycles");
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output bit ok, output logic [7:0] data, output int unsigned c);
      ok = 1'b0;
      data = 8'hxx;
      c = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1) begin
            ok = 1'b1;
            data = bus.rsp_rdata;
            c = cyc;
            return;
         end
      end
      tests++;
      fails++;
      $display("FAIL rsp_timeout: got no rsp_valid, expected it within 20 cycles");
   endtask

   task automatic do_read(input logic [7:0] a, output logic [7:0] data, output int unsigned lat);
      int unsigned acc;
      int unsigned c;
      bit ok;
      issue(1'b0, a, 8'h00, acc);
      wait_rsp(ok, data, c);
      lat = c - acc;
      @(posedge clk);
      #1;
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int unsigned a0, a1, a2, lat, c;
      logic [7:0] rd;
      bit ok;

      rst = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 8'h00;
      bus.req_wdata = 8'h00;
      bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("reset_ctrl", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
      chk("reset_addr", {24'd0, ram_address}, 32'd0);
      sync();

      // write 0xAA to 0x01, WR exactly one cycle, then read back
      issue(1'b1, 8'h01, 8'hAA, a0);
      @(negedge clk);
      chk("wr_pins", {29'd0, ram_cs, ram_we, ram_oe}, 32'b110);
      chk("wr_data", {24'd0, ram_data}, 32'hAA);
      chk("wr_addr", {24'd0, ram_address}, 32'h01);
      sync();
      @(negedge clk);
      chk("wr_one_cycle_cs", {31'd0, ram_cs}, 32'd0);
      sync();
      do_read(8'h01, rd, lat);
      chk("rd_01_data", {24'd0, rd}, 32'hAA);
      chk("rd_latency", lat, 32'd2);

      // back-to-back writes with req_valid held high
      issue(1'b1, 8'h00, 8'h11, a0);
      issue(1'b1, 8'hFF, 8'h22, a1);
      issue(1'b1, 8'h80, 8'h33, a2);
      chk("b2b_gap1", a1 - a0, 32'd2);
      chk("b2b_gap2", a2 - a1, 32'd2);
      do_read(8'h00, rd, lat);
      chk("rd_00", {24'd0, rd}, 32'h11);
      do_read(8'hFF, rd, lat);
      chk("rd_FF", {24'd0, rd}, 32'h22);
      do_read(8'h80, rd, lat);
      chk("rd_80", {24'd0, rd}, 32'h33);

      // response stalled for 5 cycles
      bus.rsp_ready = 1'b0;
      issue(1'b0, 8'hFF, 8'h00, a0);
      wait_rsp(ok, rd, c);
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
         chk("stall_rdata", {24'd0, bus.rsp_rdata}, 32'h22);
         chk("stall_ready", {31'd0, bus.req_ready}, 32'd0);
         chk("stall_cs_oe", {30'd0, ram_cs, ram_oe}, 32'd0);
         @(negedge clk);
      end
      sync();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("stall_release_valid", {31'd0, bus.rsp_valid}, 32'd1);
      sync();
      @(negedge clk);
      chk("after_hs_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("after_hs_ready", {31'd0, bus.req_ready}, 32'd1);
      sync();

      // alternating write/read stream
      for (int i = 0; i < 4; i++) begin
         logic [7:0] ad, dd;
         ad = 8'h40 + 8'(i);
         dd = 8'h05 + 8'(16 * i);
         issue(1'b1, ad, dd, a0);
         do_read(ad, rd, lat);
         chk("alt_rd", {24'd0, rd}, {24'd0, dd});
      end

      // reset while in RD_DATA
      issue(1'b0, 8'h01, 8'h00, a0);
      sync();
      rst = 1'b1;
      sync();
      rst = 1'b0;
      @(negedge clk);
      chk("rstrd_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rstrd_ctrl", {29'd0, ram_cs, ram_we, ram_oe}, 32'd0);
      chk("rstrd_ready", {31'd0, bus.req_ready}, 32'd0);
      sync();
      do_read(8'h01, rd, lat);
      chk("rstrd_reread", {24'd0, rd}, 32'hAA);

      // reset held 3 cycles with a request pending
      rst = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 8'h02;
      bus.req_wdata = 8'h5A;
      for (int k = 1; k <= 3; k++) begin
         sync();
         if (k == 3) rst = 1'b0;
         @(negedge clk);
         chk("rst3_ready_low", {31'd0, bus.req_ready}, 32'd0);
      end
      @(negedge clk);
      chk("rst3_ready_high", {31'd0, bus.req_ready}, 32'd1);
      sync();
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("rst3_wr_pins", {29'd0, ram_cs, ram_we, ram_oe}, 32'b110);
      chk("rst3_wr_addr", {24'd0, ram_address}, 32'h02);
      sync();
      do_read(8'h02, rd, lat);
      chk("rst3_rd", {24'd0, rd}, 32'h5A);

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ram_sp_ctrl.md
# ram_sp_ctrl

Request/response front-end controller for the single-port synchronous RAM (`ram_sp_sr_sw`, shared tristate data bus, `cs`/`we`/`oe` control).
- Accepts word read/write requests on a valid/ready interface and sequences the RAM control pins cycle by cycle.
- Owns the controller side of the bidirectional `data` bus and inserts bus turnaround.
- Returns read data on a backpressured response channel.

## Interface
- DATA_WIDTH, 8, word width; must match the RAM.
- ADDR_WIDTH, 8, address width; must match the RAM.

Clock, reset and request channel:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  word address.
- req_wdata  input  DATA_WIDTH  write data, ignored for reads.

Response channel:
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  downstream accepts the response.
- rsp_rdata  output  DATA_WIDTH  read data.

RAM side:
- ram_address  output  ADDR_WIDTH  RAM address.
- ram_data  inout  DATA_WIDTH  shared data bus; driven only in WR, otherwise z.
- ram_cs  output  1  RAM chip select.
- ram_we  output  1  RAM write enable.
- ram_oe  output  1  RAM output enable.

## Operation
- States: IDLE, WR, RD_ADDR, RD_DATA, RSP.

Handshake and request capture:
- A request is accepted on a rising edge with req_valid=1 and req_ready=1.
- req_ready=1 only in IDLE and is registered, not combinational from req_valid.
- On acceptance, req_we, req_addr and req_wdata are captured into internal registers. The upstream may change them afterwards.

State transitions:
- IDLE: cs=we=oe=0, bus z.
  - Accepted write goes to WR.
  - Accepted read goes to RD_ADDR.
- WR: cs=1, we=1, oe=0, ram_address and ram_data driven from the captured registers.
  - The RAM commits the word at the edge ending WR.
  - Next state is IDLE. Writes produce no response.
- RD_ADDR: cs=1, we=0, oe=1, ram_address driven, bus z. The RAM registers read data at the edge ending this state.
- RD_DATA: same pin values as RD_ADDR.
  - ram_data is sampled into rsp_rdata at the edge ending RD_DATA.
  - Next state is RSP.
- RSP: cs=we=oe=0, bus released; this cycle is the read-to-write turnaround.
  - rsp_valid=1 and rsp_rdata held stable until the edge where rsp_ready=1.
  - On that edge the next state is IDLE and rsp_valid clears.

Output and bus rules:
- ram_address holds its last value outside WR/RD states.
- The controller never drives ram_data while ram_oe=1.
- ram_we=1 implies ram_oe=0.

Reset (rst=1 at an edge):
- Next state is IDLE. req_ready=0 in the cycle immediately after reset, then 1.
- rsp_valid=0, rsp_rdata=0, ram_address=0, cs=we=oe=0, bus z.
- Reset mid-operation aborts the operation:
  - A write in WR when rst is sampled is still committed by the RAM at that edge. This is not prevented.
  - A read in progress is discarded and no response is issued.
- rst has priority over every handshake at the same edge.

## Timing
- Write: accepted at edge E0, WR in cycle E0–E1, memory updated at E1, req_ready=1 in cycle E1–E2.
  - Back-to-back writes sustain one write per 2 cycles.
- Read: accepted at E0, RD_ADDR in E0–E1, RD_DATA in E1–E2, rsp_valid=1 from E2.
  - With rsp_ready held high, the response handshakes at E3 and req_ready=1 in E3–E4.
  - Minimum read-to-next-accept is 4 cycles.
- A response stalled by rsp_ready=0 holds every output unchanged; no new request is accepted meanwhile.
- Address 2^ADDR_WIDTH−1 is handled like any other address; there is no auto-increment and no wrap logic.

## Test plan
- Write 0xAA to 0x01, then read 0x01 → WR lasts exactly one cycle with ram_data=0xAA; rsp_rdata=0xAA with rsp_valid asserted 2 cycles after read acceptance.
- Writes of 0x11, 0x22, 0x33 to 0x00, 0xFF, 0x80 with req_valid held high → accepted every 2 cycles; readbacks return 0x11, 0x22, 0x33.
- Read with rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stay stable, req_ready=0 throughout, cs=oe=0; one handshake once rsp_ready=1.
- Alternating write/read stream → every cycle: ram_data driven by the controller implies ram_we=1 and ram_oe=0; at least one all-deasserted cycle between a read's RD_DATA and the next WR.
- rst in RD_DATA → next cycle in IDLE state, rsp_valid=0, all RAM controls 0, bus z; the next read of the same address returns correct data.
- rst held for 3 cycles with req_valid=1 → no acceptance; req_ready=0 until one cycle after rst deasserts.
